// File: rtl/accel_arb_pkg.sv
`default_nettype none
//==============================================================================
// Package : accel_arb_pkg
// Shared types and default widths for the accelerator memory-port arbiter.
// Rev     : 1.0
//==============================================================================
package accel_arb_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_WDATA_W     = 32;
    localparam int DEF_RDATA_W     = 512;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module : rr_arbiter
// Combinational rotating-priority select; search starts at ptr+1 and wraps.
// Rev    : 1.0
//==============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    int              w_cand;
    logic [IDX_W-1:0] w_cidx;

    // Walk from the lowest priority to the highest so the last hit wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        w_cand     = 0;
        w_cidx     = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_cand = int'(ptr) + off;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cidx = IDX_W'(w_cand);
            if (req[w_cidx]) begin
                gnt_idx = w_cidx;
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/accel_mem_arb.sv
`default_nettype none
//==============================================================================
// Module : accel_mem_arb
// Round-robin sequencer sharing the CPU accelerator memory port, with watchdog.
// Rev    : 1.0
//==============================================================================
module accel_mem_arb
    import accel_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WDATA_W     = DEF_WDATA_W,
    parameter int RDATA_W     = DEF_RDATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_wrt_en,
    input  logic [NUM_REQ-1:0]         req_rd_en,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*WDATA_W-1:0] req_wrt_data,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         req_wrt_done,
    output logic [NUM_REQ-1:0]         req_rd_valid,
    output logic [RDATA_W-1:0]         req_rd_data,
    output logic [NUM_REQ-1:0]         req_err,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_wrt_en,
    output logic                       mem_rd_en,
    output logic [WDATA_W-1:0]         mem_wrt_data,
    input  logic [RDATA_W-1:0]         mem_rd_data,
    input  logic                       mem_wrt_done,
    input  logic                       mem_rd_valid,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    arb_op_t              r_op;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_win;
    logic [ADDR_W-1:0]    r_addr;
    logic [WDATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic [NUM_REQ-1:0]   r_grant;
    logic [RDATA_W-1:0]   r_rd_data;

    logic [NUM_REQ-1:0]   w_pending;
    logic [NUM_REQ-1:0]   w_gnt_onehot;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_complete;
    logic                 w_timeout;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [WDATA_W-1:0]   w_sel_wdata;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic                 w_in_done;

    assign w_pending   = req_wrt_en | req_rd_en;
    assign w_sel_addr  = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wrt_data[w_gnt_idx*WDATA_W +: WDATA_W];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req        (w_pending),
        .ptr        (r_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    // A completion on the final counted cycle still beats the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_complete = (r_op == OP_WR) ? mem_wrt_done : mem_rd_valid;
                if (w_complete) begin
                    w_state_nxt = DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= OP_RD;
            r_ptr     <= IDX_W'(NUM_REQ - 1);
            r_win     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_grant   <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_accept ? w_gnt_onehot : '0;
            if (w_accept) begin
                r_win   <= w_gnt_idx;
                r_ptr   <= w_gnt_idx;
                r_op    <= req_wrt_en[w_gnt_idx] ? OP_WR : OP_RD;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_cnt   <= '0;
                r_err   <= 1'b0;
            end
            if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
                if (w_complete && (r_op == OP_RD)) begin
                    r_rd_data <= mem_rd_data;
                end
            end
        end
    end

    assign w_win_onehot = NUM_REQ'(1) << r_win;
    assign w_in_done    = (r_state == DONE);

    assign req_grant    = r_grant;
    assign req_wrt_done = (w_in_done && !r_err && (r_op == OP_WR)) ? w_win_onehot : '0;
    assign req_rd_valid = (w_in_done && !r_err && (r_op == OP_RD)) ? w_win_onehot : '0;
    assign req_err      = (w_in_done && r_err) ? w_win_onehot : '0;
    assign req_rd_data  = r_rd_data;

    assign mem_addr     = r_addr;
    assign mem_wrt_data = r_wdata;
    assign mem_wrt_en   = (r_state == BUSY) && (r_op == OP_WR);
    assign mem_rd_en    = (r_state == BUSY) && (r_op == OP_RD);
    assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire
